// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared constants, response layout and address-field helpers
// for the line-granular memory model.
package line_mem_pkg;

   localparam int DEF_DATA_W          = 128;
   localparam int DEF_MEM_DEPTH       = 256;
   localparam int DEF_RD_LATENCY      = 1;
   localparam int DEF_MAX_OUTSTANDING = 4;

   // Read response at the default line width; the top builds the same
   // {data, err} layout at its own DATA_W.
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  err;
   } line_resp_t;

   // Number of byte-offset bits ignored in a byte address for a given line width.
   function automatic int offs_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Width of the line index field for a given number of lines.
   function automatic int idx_bits(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/line_mem_resp_fifo.sv
// line_mem_resp_fifo: first-word-fall-through FIFO holding read responses.
// Head entry is visible on pop_data whenever empty is low.
module line_mem_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign pop_data = store[rd_ptr];

   // Pointers and occupancy; depth need not be a power of two, so wrap explicitly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         store[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/line_mem_model.sv
// line_mem_model: line-granular backing memory for the cache refill/writeback
// port. One request per cycle on req/gnt, in-order read responses after
// RD_LATENCY cycles through a response buffer with rready backpressure.
// Build option: LINE_MEM_RAND_INIT_EN fills the array with $random words at
// time zero instead of zeros.
module line_mem_model
   import line_mem_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MEM_DEPTH       = DEF_MEM_DEPTH,
   parameter int RD_LATENCY      = DEF_RD_LATENCY,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req,
   output logic                gnt,
   input  logic                we,
   input  logic [31:0]         addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                rerr,
   output logic                rvalid,
   input  logic                rready
);

   localparam int OFFS   = offs_bits(DATA_W);
   localparam int IDX_W  = idx_bits(MEM_DEPTH);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } resp_t;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0] idx;
   logic             oor;
   logic             accept;
   logic             rd_accept;
   logic             wr_accept;
   logic [CNT_W-1:0] outstanding;
   logic             pop;
   resp_t            in_resp;
   resp_t            push_resp;
   logic             push_v;
   resp_t            head;
   logic             fifo_empty;
   logic             fifo_full;
   logic             unused_addr_offs;

   assign idx              = addr[OFFS +: IDX_W];
   assign oor              = |(addr >> (OFFS + IDX_W));
   assign unused_addr_offs = ^addr[OFFS-1:0];

   // Credit comes only from the registered count, so a pop frees a slot one cycle later.
   assign gnt       = rst_ni && (outstanding < CNT_W'(MAX_OUTSTANDING));
   assign accept    = req && gnt;
   assign rd_accept = accept && !we;
   assign wr_accept = accept && we && !oor;

   assign in_resp.data = oor ? '0 : mem[idx];
   assign in_resp.err  = oor;

`ifdef LINE_MEM_RAND_INIT_EN
   // Time-zero fill with random 32-bit words to expose reads of unwritten lines.
   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         for (int w = 0; w < DATA_W / 32; w++) begin
            mem[i][w*32 +: 32] = $random;
         end
      end
   end
`else
   // Time-zero fill with zeros; the array is never touched by reset.
   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         mem[i] = '0;
      end
   end
`endif

   // Byte-masked line write; out-of-range writes are excluded by wr_accept.
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   // The response FIFO push itself is one register stage, so the explicit
   // pipeline is RD_LATENCY-1 deep and the read line is captured at acceptance.
   generate
      if (RD_LATENCY == 1) begin : g_direct
         assign push_v    = rd_accept;
         assign push_resp = in_resp;
      end else begin : g_pipe
         logic  stg_v [RD_LATENCY-1];
         resp_t stg_r [RD_LATENCY-1];

         // Valid bits of the latency pipeline; cleared by reset to drop in-flight reads.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < RD_LATENCY - 1; i++) begin
                  stg_v[i] <= 1'b0;
               end
            end else begin
               stg_v[0] <= rd_accept;
               for (int i = 1; i < RD_LATENCY - 1; i++) begin
                  stg_v[i] <= stg_v[i-1];
               end
            end
         end

         // Data/err payload shifts alongside the valid bits.
         always_ff @(posedge clk_i) begin
            stg_r[0] <= in_resp;
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
               stg_r[i] <= stg_r[i-1];
            end
         end

         assign push_v    = stg_v[RD_LATENCY-2];
         assign push_resp = stg_r[RD_LATENCY-2];
      end
   endgenerate

   line_mem_resp_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH ($bits(resp_t))
   ) u_resp_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push_v),
      .push_data (push_resp),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign rvalid = !fifo_empty;
   assign pop    = rvalid && rready;
   assign rdata  = rvalid ? head.data : '0;
   assign rerr   = rvalid && head.err;

   // Outstanding reads: accepted but not yet popped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= '0;
      end else begin
         case ({rd_accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Credit accounting guarantees the buffer never sees a push while full.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    push_v |-> !fifo_full);

endmodule

// File: tb/tb_line_mem_model.sv
// tb_line_mem_model: directed test of line_mem_model with RD_LATENCY=3,
// default width/depth/outstanding, zero-initialised array.
module tb_line_mem_model;

   localparam int DATA_W = 128;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req;
   logic              gnt;
   logic              we;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [15:0]       wstrb;
   logic [DATA_W-1:0] rdata;
   logic              rerr;
   logic              rvalid;
   logic              rready;

   int n_checks = 0;
   int n_errors = 0;

   line_mem_model #(
      .DATA_W          (DATA_W),
      .MEM_DEPTH       (256),
      .RD_LATENCY      (3),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (req),
      .gnt    (gnt),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .rdata  (rdata),
      .rerr   (rerr),
      .rvalid (rvalid),
      .rready (rready)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr_line(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
      req   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      wstrb = s;
      tick();
      req = 1'b0;
      we  = 1'b0;
   endtask

   // Issue one read (rready assumed 1), wait a bounded time, check and pop.
   task automatic rd_check(input string tag, input logic [31:0] a,
                           input logic [127:0] exp_d, input logic exp_e);
      req  = 1'b1;
      we   = 1'b0;
      addr = a;
      tick();
      req = 1'b0;
      for (int i = 0; i < 10 && !rvalid; i++) tick();
      chk({tag, "_rvalid"}, 128'(rvalid), 128'd1);
      chk({tag, "_rdata"}, rdata, exp_d);
      chk({tag, "_rerr"}, 128'(rerr), 128'(exp_e));
      tick();
   endtask

   function automatic logic [127:0] pat(input int k);
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(k);
      return {4{w}};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst_ni = 1'b0;
      req    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      wdata  = '0;
      wstrb  = '0;
      rready = 1'b1;

      // Reset state
      #3;
      chk("rst_rvalid", 128'(rvalid), 128'd0);
      chk("rst_rerr", 128'(rerr), 128'd0);
      chk("rst_rdata", rdata, 128'd0);
      chk("rst_gnt", 128'(gnt), 128'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      #1 chk("post_rst_gnt", 128'(gnt), 128'd1);

      // Full write, partial write, then read with latency 3
      wr_line(32'h50, 128'h11223344_55667788_99AABBCC_DDEEFF00, 16'hFFFF);
      wr_line(32'h50, {4{32'hDEADBEEF}}, 16'h000F);
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'h50;
      chk("lat_gnt", 128'(gnt), 128'd1);
      tick();
      req = 1'b0;
      chk("lat_c1", 128'(rvalid), 128'd0);
      tick();
      chk("lat_c2", 128'(rvalid), 128'd0);
      tick();
      chk("lat_c3", 128'(rvalid), 128'd1);
      chk("lat_rdata", rdata, 128'h11223344_55667788_99AABBCC_DEADBEEF);
      chk("lat_rerr", 128'(rerr), 128'd0);
      tick();
      chk("lat_popped", 128'(rvalid), 128'd0);

      // Out-of-range read and write
      rd_check("oor_rd", 32'h0001_0000, 128'd0, 1'b1);
      wr_line(32'h0001_0000, '1, 16'hFFFF);
      rd_check("oor_wr_line0", 32'h0, 128'd0, 1'b0);
      rd_check("oor_wr_line5", 32'h50, 128'h11223344_55667788_99AABBCC_DEADBEEF, 1'b0);

      // Backpressure and credit
      for (int k = 1; k <= 4; k++) wr_line(32'(k << 4), pat(k), 16'hFFFF);
      rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req  = 1'b1;
         we   = 1'b0;
         addr = 32'((k + 1) << 4);
         chk($sformatf("bp_gnt%0d", k), 128'(gnt), 128'(k < 4));
         tick();
      end
      req = 1'b0;
      repeat (3) tick();
      chk("bp_head", rdata, pat(1));
      chk("bp_full_gnt", 128'(gnt), 128'd0);
      tick();
      chk("bp_stable_rvalid", 128'(rvalid), 128'd1);
      chk("bp_stable_rdata", rdata, pat(1));
      rready = 1'b1;
      chk("bp_no_bypass", 128'(gnt), 128'd0);
      tick();
      rready = 1'b0;
      chk("bp_gnt_back", 128'(gnt), 128'd1);
      chk("bp_order2", rdata, pat(2));
      rready = 1'b1;
      tick();
      chk("bp_order3", rdata, pat(3));
      tick();
      chk("bp_order4", rdata, pat(4));
      tick();
      chk("bp_drained", 128'(rvalid), 128'd0);

      // Read line 2 then write line 2 in the next cycle
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'h20;
      tick();
      we    = 1'b1;
      wdata = {4{32'hCAFEF00D}};
      wstrb = 16'hFFFF;
      tick();
      req = 1'b0;
      we  = 1'b0;
      for (int i = 0; i < 10 && !rvalid; i++) tick();
      chk("rw_old_rvalid", 128'(rvalid), 128'd1);
      chk("rw_old_rdata", rdata, pat(2));
      tick();
      rd_check("rw_new", 32'h20, {4{32'hCAFEF00D}}, 1'b0);

      // Reset with reads in flight
      for (int k = 1; k <= 3; k++) begin
         req  = 1'b1;
         we   = 1'b0;
         addr = 32'(k << 4);
         tick();
      end
      req    = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("midrst_rvalid", 128'(rvalid), 128'd0);
      chk("midrst_gnt", 128'(gnt), 128'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | rvalid;
      end
      chk("midrst_no_rvalid", 128'(seen), 128'd0);
      rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req  = 1'b1;
         we   = 1'b0;
         addr = 32'((k + 1) << 4);
         chk($sformatf("midrst_gnt%0d", k), 128'(gnt), 128'(k < 4));
         tick();
      end
      req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/line_mem_model.md
# line_mem_model

Parametrised line-granular memory model that backs the cache's refill/writeback port in simulation and FPGA prototypes. Accepts one request per cycle on a req/gnt handshake, returns read lines in order after a configurable latency through a response buffer with rready backpressure, and flags out-of-range addresses. Successor to the fixed 128-bit, fixed 1-cycle, no-backpressure memory model.

## Interface

Parameters:
- DATA_W, 128: line width in bits; multiple of 8, power of two, at least 32.
- MEM_DEPTH, 256: number of lines; power of two.
- RD_LATENCY, 1: cycles from read acceptance to earliest rvalid; at least 1.
- MAX_OUTSTANDING, 4: accepted reads not yet popped; also the response buffer depth; at least 1.

Ports:
- clk_i, in, 1: clock; all logic on rising edge.
- rst_ni, in, 1: asynchronous, active-low reset.
- req, in, 1: request valid.
- gnt, out, 1: request accepted this cycle when req && gnt.
- we, in, 1: 1 = write, 0 = read.
- addr, in, 32: byte address; low OFFS = log2(DATA_W/8) bits ignored.
- wdata, in, DATA_W: write line.
- wstrb, in, DATA_W/8: byte enables for write.
- rdata, out, DATA_W: read line, valid with rvalid.
- rerr, out, 1: read hit an out-of-range address, valid with rvalid.
- rvalid, out, 1: response at head of buffer.
- rready, in, 1: consumer takes response when rvalid && rready.

## Operation

- Index = addr[OFFS +: log2(MEM_DEPTH)]; address is out of range if any addr bit above the index field is 1.
- gnt = rst_ni && (outstanding < MAX_OUTSTANDING), derived from the registered count only; no same-cycle bypass of a pop. gnt gates writes as well as reads.
- Accepted write: bytes with wstrb[i]=1 updated at that edge; out-of-range write dropped silently; no response.
- Accepted read: line sampled from the array at the acceptance edge (later writes do not alter an in-flight read); pushed into a RD_LATENCY-stage valid/data/err pipeline; out-of-range read carries rdata = 0, rerr = 1.
- Pipeline output enters the response buffer (depth MAX_OUTSTANDING); cannot overflow because of gnt credit accounting.
- rvalid = buffer non-empty; rdata/rerr show head; held stable while rvalid && !rready.
- outstanding: +1 on accepted read, -1 on pop, unchanged on both together; range 0..MAX_OUTSTANDING.
- Responses strictly in acceptance order.
- Write then read to same index in consecutive cycles: read returns written data.

## Timing

- Reset (rst_ni low, async): outstanding = 0, pipeline valids = 0, buffer empty; rvalid = 0, rerr = 0, rdata = 0, gnt = 0. Array contents not reset.
- First cycle after reset release: gnt = 1.
- Read accepted in cycle 0 with empty buffer: rvalid = 1 in cycle RD_LATENCY.
- Back-to-back reads with rready held 1: one response per cycle, throughput 1/cycle when MAX_OUTSTANDING >= RD_LATENCY + 1.
- Pop in cycle N frees credit: gnt rises in cycle N+1 at the earliest.
- Reset asserted mid-operation: all in-flight reads and buffered responses discarded; no rvalid afterwards until new reads are accepted.

## Configuration

- LINE_MEM_RAND_INIT_EN defined: array initialised at time zero with $random per 32-bit word.
- Undefined: array initialised to all zeros.
- No other behaviour changes.

## Structure

- Package line_mem_pkg holds the response typedef {data, err}, the OFFS/index-width helper functions, and the default parameter constants.
- One sub-module: line_mem_resp_fifo, a synchronous FIFO with parametrised depth and width. It has a push/pop interface, empty/full outputs, and asynchronous active-low reset of the pointers.
- The top level contains the array, address decode, latency pipeline and credit counter.

## Test plan

- Reset then idle: rvalid=0, rerr=0, rdata=0 during reset. gnt=0 during reset and 1 in the first cycle after release.
- Write 0xDEADBEEF... to line 5 with wstrb=0x000F, then read line 5 with RD_LATENCY=3: rvalid is high exactly 3 cycles after acceptance. Low 4 bytes are 0xDEADBEEF and the remaining bytes are unchanged.
- Read with addr=0x0001_0000 (out of range at default depth): rerr=1 and rdata=0. A write to that address leaves all lines unchanged.
- rready=0 while issuing reads with MAX_OUTSTANDING=4: 4 reads are granted and gnt drops on the 5th. rdata stays stable. Raising rready for 1 cycle pops one entry and gnt returns the next cycle. Order is preserved.
- Read line 2, then write line 2 in the next cycle: the read returns the old data.
- Assert rst_ni low with 3 reads in flight: after release no rvalid appears and outstanding is 0 (4 new reads are granted).
